// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the default instruction word shown when IF/ID is empty, and the branch
// offset helper used by the decode-side outputs.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } ifetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // sign_extend(instr[15:0]) << 2
    function automatic logic [31:0] branch_off(input logic [31:0] instr);
        return {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid
// One-entry buffer that parks a returned instruction while decode is stalled
// and IF/ID is already occupied.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_push           capture i_data/i_pc4/i_mis, mark full
//   i_pop            empty the buffer (consumed or discarded)
//   o_full           buffer holds a word
//   o_data/o_pc4/o_mis  buffered instruction, its PC+4, misaligned flag
module ifetch_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [31:0] i_data,
    input  logic [31:0] i_pc4,
    input  logic        i_mis,
    output logic        o_full,
    output logic [31:0] o_data,
    output logic [31:0] o_pc4,
    output logic        o_mis
);

    logic        r_full;
    logic [31:0] r_data;
    logic [31:0] r_pc4;
    logic        r_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= 32'd0;
            r_pc4  <= 32'd0;
            r_mis  <= 1'b0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_pc4  <= i_pc4;
            r_mis  <= i_mis;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_pc4  = r_pc4;
    assign o_mis  = r_mis;

endmodule

// File: rtl/ifetch.sv
// ifetch
// Instruction-fetch stage: issues one instruction-memory request at a time,
// loads the returned word into the IF/ID register, parks it in a skid buffer
// while decode stalls, and squashes fetches on flush.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   pc, pc_plus_4         current PC and PC+4 from the PC logic
//   stall, flush          decode back-pressure, redirect
//   imem_req/imem_addr    request and word-aligned address
//   imem_ready            request accepted this cycle
//   imem_rvalid/imem_rdata  read data return
//   pc_advance            PC register enable
//   if_id_*               IF/ID pipeline register contents
//   branch_offset         sign-extended, word-scaled immediate of IF/ID instr
//   jump_target           26-bit jump field of IF/ID instr
//
// state | meaning
// IDLE  | just out of reset, no request yet
// REQ   | request presented, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid (kill => discard it)
// HOLD  | returned word parked in skid buffer until stall drops
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus_4,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        pc_advance,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus_4,
    output logic        if_id_misaligned,
    output logic [31:0] branch_offset,
    output logic [25:0] jump_target
);

    ifetch_state_t r_state;
    ifetch_state_t w_state_nxt;
    logic          r_kill;
    logic          w_kill_nxt;
    logic [31:0]   r_pend_pc4;
    logic          r_pend_mis;

    logic          w_accept;
    logic          w_load_mem;
    logic          w_load_skid;
    logic          w_skid_push;
    logic          w_skid_pop;
    logic          w_skid_full;
    logic [31:0]   w_skid_data;
    logic [31:0]   w_skid_pc4;
    logic          w_skid_mis;

    logic          r_if_valid;
    logic [31:0]   r_if_instr;
    logic [31:0]   r_if_pc4;
    logic          r_if_mis;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_kill     <= 1'b0;
            r_pend_pc4 <= 32'd0;
            r_pend_mis <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            if (w_accept) begin
                r_pend_pc4 <= pc_plus_4;
                r_pend_mis <= (pc[1:0] != 2'b00);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_accept    = 1'b0;
        w_load_mem  = 1'b0;
        w_load_skid = 1'b0;
        w_skid_push = 1'b0;
        w_skid_pop  = 1'b0;
        imem_req    = 1'b0;
        pc_advance  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                    // a request accepted during a redirect fetches a stale PC
                    w_kill_nxt  = flush;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = ST_REQ;
                    w_kill_nxt  = 1'b0;
                    if (!flush && !r_kill) begin
                        if (!stall || !r_if_valid) begin
                            w_load_mem = 1'b1;
                            pc_advance = 1'b1;
                        end else begin
                            w_skid_push = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end else if (flush) begin
                    w_kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    w_skid_pop  = 1'b1;
                    w_state_nxt = ST_REQ;
                end else if (!stall && w_skid_full) begin
                    w_load_skid = 1'b1;
                    w_skid_pop  = 1'b1;
                    pc_advance  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    ifetch_skid u_skid (
        .clk    (clk),
        .rst_n  (reset),
        .i_push (w_skid_push),
        .i_pop  (w_skid_pop),
        .i_data (imem_rdata),
        .i_pc4  (r_pend_pc4),
        .i_mis  (r_pend_mis),
        .o_full (w_skid_full),
        .o_data (w_skid_data),
        .o_pc4  (w_skid_pc4),
        .o_mis  (w_skid_mis)
    );

    // An empty IF/ID shows NOP_INSTR; pc_plus_4 is left as last loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_pc4   <= 32'd0;
            r_if_mis   <= 1'b0;
        end else if (flush) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_mis   <= 1'b0;
        end else if (w_load_mem) begin
            r_if_valid <= 1'b1;
            r_if_instr <= imem_rdata;
            r_if_pc4   <= r_pend_pc4;
            r_if_mis   <= r_pend_mis;
        end else if (w_load_skid) begin
            r_if_valid <= 1'b1;
            r_if_instr <= w_skid_data;
            r_if_pc4   <= w_skid_pc4;
            r_if_mis   <= w_skid_mis;
        end else if (!stall) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_mis   <= 1'b0;
        end
    end

    assign imem_addr        = {pc[31:2], 2'b00};
    assign if_id_valid      = r_if_valid;
    assign if_id_instr      = r_if_instr;
    assign if_id_pc_plus_4  = r_if_pc4;
    assign if_id_misaligned = r_if_mis;
    assign branch_offset    = branch_off(r_if_instr);
    assign jump_target      = r_if_instr[25:0];

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch
// Directed bench for ifetch. Each accepted fetch pushes its expected IF/ID
// contents into a queue; a monitor pops and compares one entry in the cycle
// after every pc_advance pulse. Discarded words push nothing, so any stray
// load shows up as an unexpected pop.
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pc_advance;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus_4;
    logic        if_id_misaligned;
    logic [31:0] branch_offset;
    logic [25:0] jump_target;

    assign pc_plus_4 = pc + 32'd4;

    ifetch #(.NOP_INSTR(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .pc_plus_4        (pc_plus_4),
        .stall            (stall),
        .flush            (flush),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .pc_advance       (pc_advance),
        .if_id_valid      (if_id_valid),
        .if_id_instr      (if_id_instr),
        .if_id_pc_plus_4  (if_id_pc_plus_4),
        .if_id_misaligned (if_id_misaligned),
        .branch_offset    (branch_offset),
        .jump_target      (jump_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic load_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (load_pending) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_load: got instr %h, expected no load at %0t", if_id_instr, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_valid", 32'(if_id_valid), 32'd1);
                chk("sb_instr", if_id_instr, mon_e.instr);
                chk("sb_pc4", if_id_pc_plus_4, mon_e.pc4);
                chk("sb_misaligned", 32'(if_id_misaligned), 32'(mon_e.mis));
            end
        end
        load_pending = pc_advance;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the DUT in REQ and stall low. Returns at
    // posedge+1 of the cycle in which IF/ID shows the word.
    task automatic fetch(input logic [31:0] p, input logic [31:0] word,
                         input logic [31:0] exp_addr, input logic [31:0] exp_pc4,
                         input logic exp_mis);
        exp_t e;
        pc         = p;
        imem_ready = 1'b1;
        e.instr = word;
        e.pc4   = exp_pc4;
        e.mis   = exp_mis;
        sb.push_back(e);
        @(negedge clk);
        chk("req_high", 32'(imem_req), 32'd1);
        chk("req_addr", imem_addr, exp_addr);
        chk("adv_idle_req", 32'(pc_advance), 32'd0);
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        chk("req_low_wait", 32'(imem_req), 32'd0);
        chk("adv_on_rvalid", 32'(pc_advance), 32'd1);
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        pc          = 32'd0;
        stall       = 1'b0;
        flush       = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;

        // Reset values before any clock edge.
        #2;
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_instr", if_id_instr, 32'h0000_0000);
        chk("rst_pc4", if_id_pc_plus_4, 32'd0);
        chk("rst_mis", 32'(if_id_misaligned), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_adv", 32'(pc_advance), 32'd0);

        @(posedge clk);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();

        // Basic fetch, minimum latency.
        fetch(32'h100, 32'h2008000A, 32'h100, 32'h104, 1'b0);

        // Stall with IF/ID occupied: word goes to the skid buffer.
        stall      = 1'b1;
        pc         = 32'h104;
        imem_ready = 1'b1;
        sb.push_back('{instr: 32'h8C020004, pc4: 32'h108, mis: 1'b0});
        @(negedge clk);
        chk("adv_pulse_1cyc", 32'(pc_advance), 32'd0);
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C020004;
        @(negedge clk);
        chk("skid_no_adv", 32'(pc_advance), 32'd0);
        chk("stall_hold_instr", if_id_instr, 32'h2008000A);
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("hold_no_adv", 32'(pc_advance), 32'd0);
        chk("hold_valid", 32'(if_id_valid), 32'd1);
        chk("hold_instr", if_id_instr, 32'h2008000A);
        chk("hold_req", 32'(imem_req), 32'd0);
        tick();
        stall = 1'b0;
        @(negedge clk);
        chk("release_adv", 32'(pc_advance), 32'd1);
        tick();

        // Flush (with stall) while waiting; late word must be dropped.
        stall      = 1'b1;
        pc         = 32'h200;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("skid_adv_1cyc", 32'(pc_advance), 32'd0);
        chk("req_after_hold", 32'(imem_req), 32'd1);
        tick();
        imem_ready = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        chk("flush_no_adv", 32'(pc_advance), 32'd0);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(if_id_valid), 32'd0);
        chk("flush_instr", if_id_instr, 32'h0000_0000);
        chk("kill_wait_req", 32'(imem_req), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h12345678;
        @(negedge clk);
        chk("kill_no_adv", 32'(pc_advance), 32'd0);
        tick();
        imem_rvalid = 1'b0;
        pc          = 32'h300;
        @(negedge clk);
        chk("kill_req", 32'(imem_req), 32'd1);
        chk("kill_new_addr", imem_addr, 32'h300);
        chk("kill_valid", 32'(if_id_valid), 32'd0);
        tick();

        // Decode-side fields.
        fetch(32'h300, 32'h0800_0040, 32'h300, 32'h304, 1'b0);
        @(negedge clk);
        chk("jump_target", 32'(jump_target), 32'h0000040);
        tick();
        fetch(32'h304, 32'h1000FFFF, 32'h304, 32'h308, 1'b0);
        @(negedge clk);
        chk("branch_offset", branch_offset, 32'hFFFFFFFC);
        tick();

        // Misaligned PC.
        fetch(32'h102, 32'h24020005, 32'h100, 32'h106, 1'b1);

        // Flush and rvalid in the same WAIT cycle.
        pc         = 32'h400;
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        flush       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        chk("flush_rv_no_adv", 32'(pc_advance), 32'd0);
        tick();
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        fetch(32'h404, 32'hAAAA5555, 32'h404, 32'h408, 1'b0);

        // Reset in the middle of WAIT with IF/ID occupied.
        stall      = 1'b1;
        pc         = 32'h500;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        reset      = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(if_id_valid), 32'd0);
        chk("mid_rst_instr", if_id_instr, 32'h0000_0000);
        chk("mid_rst_pc4", if_id_pc_plus_4, 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_adv", 32'(pc_advance), 32'd0);
        tick();
        reset       = 1'b1;
        stall       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h55555555;
        @(negedge clk);
        chk("late_rv_idle_req", 32'(imem_req), 32'd0);
        chk("late_rv_idle_adv", 32'(pc_advance), 32'd0);
        tick();
        @(negedge clk);
        chk("late_rv_req", 32'(imem_req), 32'd1);
        chk("late_rv_adv", 32'(pc_advance), 32'd0);
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rv_valid", 32'(if_id_valid), 32'd0);
        chk("late_rv_req2", 32'(imem_req), 32'd1);
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the instruction word presented when IF/ID holds no valid instruction.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pc  input  32  current PC from the PC register.
REQ-005 pc_plus_4  input  32  PC+4 from the PC logic.
REQ-006 stall  input  1  decode cannot accept; IF/ID SHALL hold.
REQ-007 flush  input  1  redirect; squash IF/ID and any in-flight fetch.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  word-aligned fetch address.
REQ-010 imem_ready  input  1  memory accepts request this cycle.
REQ-011 imem_rvalid  input  1  read data valid this cycle.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 pc_advance  output  1  PC register enable; the PC register SHALL update only when high.
REQ-014 if_id_valid  output  1  IF/ID holds a live instruction.
REQ-015 if_id_instr  output  32  registered instruction.
REQ-016 if_id_pc_plus_4  output  32  PC+4 of that instruction.
REQ-017 if_id_misaligned  output  1  pc[1:0] was nonzero at request.
REQ-018 branch_offset  output  32  sign_extend(if_id_instr[15:0]) << 2, combinational.
REQ-019 jump_target  output  26  if_id_instr[25:0], combinational.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, HOLD.
REQ-021 IDLE: entered on reset; SHALL move to REQ on the first clock edge after reset release.
REQ-022 REQ: imem_req=1, imem_addr={pc[31:2],2'b00}; on imem_ready=1 latch pc_plus_4 and pc[1:0]!=0, go WAIT; otherwise remain.
REQ-023 imem_req SHALL be 0 in IDLE, WAIT, HOLD; at most one request outstanding.
REQ-024 WAIT, imem_rvalid=1, kill flag clear, (stall=0 or if_id_valid=0): load IF/ID, pc_advance=1 this cycle, go REQ.
REQ-025 WAIT, imem_rvalid=1, kill clear, stall=1 and if_id_valid=1: store word in 1-entry skid buffer, go HOLD, pc_advance=0.
REQ-026 HOLD: when stall=0, move buffer to IF/ID, pc_advance=1, go REQ.
REQ-027 WAIT with kill flag set: on imem_rvalid discard data, clear kill, go REQ, pc_advance=0.
REQ-028 flush (priority over stall): next edge if_id_valid=0, if_id_instr=NOP_INSTR; in WAIT set kill; in HOLD discard buffer, go REQ; pc_advance=0 in the flush cycle.
REQ-029 flush and imem_rvalid in the same WAIT cycle: data SHALL be discarded, kill left clear, go REQ.
REQ-030 stall=1, no flush: IF/ID outputs SHALL hold their values.
REQ-031 IF/ID load with stall=0 and no new word: if_id_valid SHALL drop to 0 after consumption.
REQ-032 Minimum latency: imem_ready in cycle N, imem_rvalid in N+1 -> if_id_valid=1 from N+2; peak rate one instruction per 2 cycles.

Reset
REQ-033 Reset asserted: state=IDLE, kill=0, buffer empty, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc_plus_4=0, if_id_misaligned=0, imem_req=0, pc_advance=0, immediately and regardless of clk.
REQ-034 Reset mid-WAIT: a late imem_rvalid after release SHALL be ignored (FSM in IDLE/REQ).

Structure
REQ-035 Shared package SHALL hold the FSM state encoding and NOP_INSTR default.
REQ-036 Optional sub-module ifetch_skid (1-entry buffer: data, pc_plus_4, misaligned, full flag).

Verification
REQ-037 pc=0x100, ready same cycle, rvalid next with 0x2008000A -> if_id_instr=0x2008000A, if_id_pc_plus_4=0x104, pc_advance pulse 1 cycle.
REQ-038 if_id_valid=1, stall=1 when rvalid with 0x8C020004 -> HOLD; release stall -> IF/ID=0x8C020004, one pc_advance pulse.
REQ-039 flush in WAIT, rvalid 2 cycles later with 0x12345678 -> word discarded, if_id_valid=0, next REQ uses new pc.
REQ-040 if_id_instr=0x0800_0040 -> jump_target=0x0000040; if_id_instr=0x1000FFFF -> branch_offset=0xFFFFFFFC.
REQ-041 pc=0x102 -> imem_addr=0x100, if_id_misaligned=1.
REQ-042 reset low during WAIT, rvalid 1 cycle after release -> if_id_valid stays 0, imem_req rises in REQ.
